serial_adder_ctrl: RTL and testbench

//  Bit-serial add/subtract controller that time-shares one 1-bit full-adder slice across N-bit operands.
//  The slice is built from two half_adder instances plus an OR gate.

---
 rtl/serial_adder_ctrl_pkg.sv | 17 +
 rtl/serial_adder_ctrl_if.sv | 44 ++++
 rtl/serial_adder_ctrl_fa.sv | 50 +++++
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract controller:
//   FSM state encoding and the default operand width.
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_N = 8;

  // 2-bit state encoding; code 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Request/response bundle between a requester and serial_adder_ctrl.
//
//   Handshake: the requester raises start with sub/ip1/ip2 valid; the
//   controller accepts it on a rising edge only while idle (busy=0). While
//   busy=1 start and operands are ignored, not queued. done pulses for one
//   cycle when sum/carry become valid; sum/carry then hold until the next
//   accepted start.
//
//   Signals:
//     start  requester -> ctrl   request, sampled only while idle
//     sub    requester -> ctrl   0 = ip1+ip2, 1 = ip1-ip2
//     ip1    requester -> ctrl   operand A [N-1:0]
//     ip2    requester -> ctrl   operand B [N-1:0]
//     busy   ctrl -> requester   high while an operation is in flight
//     done   ctrl -> requester   one-cycle completion pulse
//     sum    ctrl -> requester   result [N-1:0]
//     carry  ctrl -> requester   carry-out (sub: 1 = no borrow)
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int N = 8
);

  logic         start;
  logic         sub;
  logic [N-1:0] ip1;
  logic [N-1:0] ip2;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry;

  modport master (
    output start, sub, ip1, ip2,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, sub, ip1, ip2,
    output busy, done, sum, carry
  );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_fa.sv
// -----------------------------------------------------------------------------
// half_adder / bit_full_adder
//   The single 1-bit adder slice time-shared by serial_adder_ctrl.
//   bit_full_adder is two half adders plus an OR for the carry.
//
//   half_adder ports:     i_a, i_b -> o_s (a^b), o_c (a&b)
//   bit_full_adder ports: i_a, i_b, i_cin -> o_s, o_cout
// -----------------------------------------------------------------------------
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule : half_adder

module bit_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha1 (
    .i_a (w_s1),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c2)
  );

  // At most one of the half-adder carries can be set.
  assign o_cout = w_c1 | w_c2;

endmodule : bit_full_adder

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract controller. Captures N-bit operands on an accepted
//   start, then feeds one bit per clock (LSB first) through a single shared
//   full-adder slice, keeping the inter-bit carry in a flop. Subtraction uses
//   inverted B with carry-in 1.
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset, overrides everything
//     bus          serial_adder_ctrl_if.slave (start/sub/ip1/ip2 in,
//                  busy/done/sum/carry out)
//     o_dbg_state  current FSM state, for observation only
//
//   Timing: start sampled at edge 0, bit k processed at edge k+1, done high in
//   the cycle after edge N, back to idle after edge N+1, so the earliest next
//   accepted start is edge N+2.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus,
  output state_t               o_dbg_state
);

  localparam int          CW     = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_cff;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_busy;
  logic           r_done;

  logic           w_s;
  logic           w_cout;

  bit_full_adder u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_cff),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cff   <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.ip1;
            // Two's complement subtract: invert B here, carry-in 1 below.
            r_b     <= bus.sub ? ~bus.ip2 : bus.ip2;
            r_cff   <= bus.sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Result bits enter at the MSB so after N shifts bit 0 is at sum[0].
          r_sum <= {w_s, r_sum[N-1:1]};
          r_a   <= {1'b0, r_a[N-1:1]};
          r_b   <= {1'b0, r_b[N-1:1]};
          r_cff <= w_cout;
          if (r_cnt == LAST) begin
            // Counter holds at N-1; it is reloaded on the next accepted start.
            r_carry <= w_cout;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum     = r_sum;
  assign bus.carry   = r_carry;
  assign o_dbg_state = r_state;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (N=8). Expected results come
//   from a plain-arithmetic model of ip1 +/- ip2 mod 256 held in exp_q.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int N = 8;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [N:0] exp_q[$];

  serial_adder_ctrl_if #(.N(N)) bus ();

  serial_adder_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // {carry, sum}: add -> 9-bit sum; sub -> carry means no borrow (a >= b).
  function automatic logic [N:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
    logic [N-1:0] diff;
    if (s) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One full operation starting at a negedge in IDLE; returns at the negedge
  // after done (controller idle again). Junk is driven on all inputs while busy.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int         cyc;
    logic [N:0] exp;
    bus.start = 1'b1;
    bus.ip1   = a;
    bus.ip2   = b;
    bus.sub   = s;
    exp_q.push_back(ref_model(a, b, s));
    @(negedge clk);
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'($urandom_range(0, 1));
      bus.ip1   = N'($urandom);
      bus.ip2   = N'($urandom);
      bus.sub   = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    check("done_latency", cyc, 32'd9);
    check("sum",   {24'd0, bus.sum},   {24'd0, exp[N-1:0]});
    check("carry", {31'd0, bus.carry}, {31'd0, exp[N]});
    check("busy_done", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("done_width", {31'd0, bus.done}, 32'd0);
    check("busy_idle",  {31'd0, bus.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          k;
    int          n_done;
    logic [N-1:0] held_sum;
    logic        held_carry;

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.ip1   = '0;
    bus.ip2   = '0;
    rst       = 1'b0;
    @(negedge clk);
    apply_reset(2);

    // Reset state
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_done",  {31'd0, bus.done},  32'd0);
    check("rst_sum",   {24'd0, bus.sum},   32'd0);
    check("rst_carry", {31'd0, bus.carry}, 32'd0);

    // 1. basic add with latency/busy checks inside do_op
    do_op(8'h0F, 8'h01, 1'b0);
    check("t1_sum", {24'd0, bus.sum}, 32'h10);

    // 2. overflow, then no-carry add
    do_op(8'hFF, 8'h01, 1'b0);
    check("t2a_sum",   {24'd0, bus.sum},   32'h00);
    check("t2a_carry", {31'd0, bus.carry}, 32'd1);
    do_op(8'hA5, 8'h5A, 1'b0);
    check("t2b_sum",   {24'd0, bus.sum},   32'hFF);
    check("t2b_carry", {31'd0, bus.carry}, 32'd0);

    // Results hold in IDLE while inputs wander with start low
    held_sum   = bus.sum;
    held_carry = bus.carry;
    repeat (4) begin
      bus.ip1 = N'($urandom);
      bus.ip2 = N'($urandom);
      bus.sub = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("hold_sum",   {24'd0, bus.sum},   {24'd0, held_sum});
    check("hold_carry", {31'd0, bus.carry}, {31'd0, held_carry});
    check("hold_busy",  {31'd0, bus.busy},  32'd0);

    // 3. subtraction with and without borrow
    do_op(8'h05, 8'h07, 1'b1);
    check("t3a_sum",   {24'd0, bus.sum},   32'hFE);
    check("t3a_carry", {31'd0, bus.carry}, 32'd0);
    do_op(8'h07, 8'h05, 1'b1);
    check("t3b_sum",   {24'd0, bus.sum},   32'h02);
    check("t3b_carry", {31'd0, bus.carry}, 32'd1);

    // 4. start held high: one op per 10 cycles, busy-time operand changes ignored
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.ip1   = 8'h01;
    bus.ip2   = 8'h01;
    n_done    = 0;
    for (k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (bus.done) begin
        check("t4_done_cycle", k, 9 + 10 * n_done);
        check("t4_sum", {24'd0, bus.sum}, 32'h02);
        n_done++;
      end
      if (bus.busy && !bus.done) begin
        bus.ip1 = N'($urandom);
        bus.ip2 = N'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
      end else begin
        bus.ip1 = 8'h01;
        bus.ip2 = 8'h01;
        bus.sub = 1'b0;
      end
    end
    check("t4_done_count", n_done, 3);
    bus.start = 1'b0;
    apply_reset(1);

    // 5. reset in the middle of RUN discards the operation
    bus.start = 1'b1;
    bus.ip1   = 8'hFF;
    bus.ip2   = 8'hFF;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_running", {30'd0, dbg_state}, {30'd0, S_RUN});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("t5_busy",  {31'd0, bus.busy},  32'd0);
    check("t5_done",  {31'd0, bus.done},  32'd0);
    check("t5_sum",   {24'd0, bus.sum},   32'd0);
    check("t5_carry", {31'd0, bus.carry}, 32'd0);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("t5_no_done", n_done, 0);

    // 6. random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    end
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
